// File: rtl/rggen_apb_bridge_master_if.sv
// Request/response bus between a register block's external-register port
// and a downstream bridge. The master issues a request and the slave answers.
// Access encoding: READ=2'b10, POSTED_WRITE=2'b01, WRITE=2'b11.
// Status encoding: OKAY=2'b00, EXOKAY=2'b01, SLAVE_ERROR=2'b10, DECODE_ERROR=2'b11.
interface rggen_apb_bridge_master_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  localparam int STROBE_WIDTH = BUS_WIDTH / 8;

  logic                     valid;
  logic [1:0]               access;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [STROBE_WIDTH-1:0]  strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_apb_bridge_master.sv
// Replays one external-register request as an APB4 master transfer and
// returns read data and status on the same request bus. All APB outputs and
// all response outputs come straight from flops. An optional watchdog aborts
// a transfer whose slave never raises pready.
module rggen_apb_bridge_master #(
  parameter int         ADDRESS_WIDTH  = 8,
  parameter int         BUS_WIDTH      = 32,
  parameter int         STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter logic [2:0] PPROT          = 3'b000,
  parameter int         TIMEOUT_CYCLES = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  rggen_apb_bridge_master_if.slave bus_if,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic                     o_pwrite,
  output logic [STROBE_WIDTH-1:0]  o_pstrb,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr
);

  localparam logic [1:0] RGGEN_READ        = 2'b10;
  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;

  // Counter needs to reach TIMEOUT_CYCLES-1; keep at least one bit so the
  // declaration stays legal when the watchdog is disabled.
  localparam int COUNT_WIDTH =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
    COUNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit WATCHDOG_ON = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                   state;
  logic [COUNT_WIDTH-1:0]   count;
  logic                     psel_q;
  logic                     penable_q;
  logic [ADDRESS_WIDTH-1:0] paddr_q;
  logic                     pwrite_q;
  logic [STROBE_WIDTH-1:0]  pstrb_q;
  logic [BUS_WIDTH-1:0]     pwdata_q;
  logic                     ready_q;
  logic [1:0]               status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;

  logic is_read;
  logic watchdog_fire;

  assign is_read       = (bus_if.access == RGGEN_READ);
  assign watchdog_fire = WATCHDOG_ON && (count == COUNT_LAST);

  // Transfer sequencer: runs the APB SETUP/ACCESS phases and raises a
  // one-cycle response once the slave completes or the watchdog expires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: every flop here is a small control/data register, so all of them
    // take the async reset; an abort mid-transfer leaves nothing stale behind.
    if (!i_rst_n) begin
      state       <= IDLE;
      count       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      ready_q     <= 1'b0;
      status_q    <= RGGEN_OKAY;
      read_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // state and count from before this edge regardless of statement order.
      case (state)
        IDLE: begin
          if (bus_if.valid) begin
            paddr_q   <= bus_if.address;
            pwrite_q  <= !is_read;
            pwdata_q  <= bus_if.write_data;
            pstrb_q   <= is_read ? '0 : bus_if.strobe;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          count     <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            read_data_q <= pwrite_q ? '0 : i_prdata;
            status_q    <= i_pslverr ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            ready_q     <= 1'b1;
            state       <= RESPONSE;
          end else if (watchdog_fire) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            read_data_q <= '0;
            status_q    <= RGGEN_SLAVE_ERROR;
            ready_q     <= 1'b1;
            state       <= RESPONSE;
          end else if (count != '1) begin
            count <= count + 1'b1;
          end
        end
        RESPONSE: begin
          // Upstream drops valid on this edge; IDLE looks again next cycle.
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_psel           = psel_q;
  assign o_penable        = penable_q;
  assign o_paddr          = paddr_q;
  assign o_pprot          = PPROT;
  assign o_pwrite         = pwrite_q;
  assign o_pstrb          = pstrb_q;
  assign o_pwdata         = pwdata_q;
  assign bus_if.ready     = ready_q;
  assign bus_if.status    = status_q;
  assign bus_if.read_data = read_data_q;

endmodule
